fc_layer: RTL and testbench

Fully-connected layer engine that sits directly downstream of the max-pool stage in the CNN accelerator. When enabled, it reads the flattened pooled feature map from the OFMAP region of the shared DRAM, multiplies it by a weight matrix, and adds a per-neuron bias. Each neuron result is written back to DRAM as one saturated fixed-point word. It uses the same single-port DRAM handshake style (`addr_in`/`addr_out`/`dram_en_rd`/`dram_en_wr`) as the other layer engines.

---
 rtl/fc_pkg.sv | 35 +++
 rtl/fc_layer_mac.sv | 42 ++++
 rtl/fc_layer.sv | 153 +++++++++++++++
 tb/tb_fc_layer.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/fc_pkg.sv
// Shared constants, state encoding and saturation helper for the fc_layer engine.
package fc_pkg;

  localparam int FC_DATA_W    = 32;
  localparam int FC_ADDR_W    = 18;
  localparam int FC_FRAC_BITS = 16;
  localparam int FC_ACC_W     = 44;
  localparam int NUM_PARAM    = 2;

  localparam logic [FC_ADDR_W-1:0] PARAM_BASE  = 18'd0;
  localparam logic [FC_ADDR_W-1:0] BIAS_BASE   = 18'd16;
  localparam logic [FC_ADDR_W-1:0] OUT_BASE    = 18'd1024;
  localparam logic [FC_ADDR_W-1:0] OFMAP_BASE  = 18'd65536;
  localparam logic [FC_ADDR_W-1:0] WEIGHT_BASE = 18'd196608;

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_LD_PARAM = 3'd1,
    S_LD_BIAS  = 3'd2,
    S_MAC      = 3'd3,
    S_FLUSH    = 3'd4,
    S_WRITE    = 3'd5,
    S_DONE     = 3'd6
  } fc_state_t;

  // In range when every bit above the data sign bit matches the sign bit.
  function automatic logic [FC_DATA_W-1:0] saturate(input logic signed [FC_ACC_W-1:0] a);
    logic [FC_ACC_W-FC_DATA_W:0] top;
    top = a[FC_ACC_W-1:FC_DATA_W-1];
    if ((top == '0) || (top == '1)) return a[FC_DATA_W-1:0];
    else if (a[FC_ACC_W-1])         return {1'b1, {(FC_DATA_W-1){1'b0}}};
    else                            return {1'b0, {(FC_DATA_W-1){1'b1}}};
  endfunction

endpackage

// File: rtl/fc_layer_mac.sv
// Accumulator for one neuron: bias load, fixed-point multiply-accumulate, saturation.
// FC_RELU_EN clamps negative results to zero at the output.
module fc_mac
  import fc_pkg::*;
#(
  parameter int DATA_WIDTH = FC_DATA_W,
  parameter int ACC_WIDTH  = FC_ACC_W,
  parameter int FRAC_BITS  = FC_FRAC_BITS
) (
  input  logic                  clk,
  input  logic                  srst,
  input  logic                  load_bias,
  input  logic                  mac_en,
  input  logic [DATA_WIDTH-1:0] x,
  input  logic [DATA_WIDTH-1:0] w,
  output logic [DATA_WIDTH-1:0] result
);

  logic signed [2*DATA_WIDTH-1:0] w_prod;
  logic signed [ACC_WIDTH-1:0]    w_term;
  logic signed [ACC_WIDTH-1:0]    r_acc;
  logic [DATA_WIDTH-1:0]          w_sat;

  assign w_prod = signed'(x) * signed'(w);
  // Bits of the shifted product above ACC_WIDTH are dropped: overflow wraps.
  assign w_term = ACC_WIDTH'(w_prod >>> FRAC_BITS);

  always_ff @(posedge clk) begin
    if (srst)           r_acc <= '0;
    else if (load_bias) r_acc <= {{(ACC_WIDTH-DATA_WIDTH){w[DATA_WIDTH-1]}}, w};
    else if (mac_en)    r_acc <= r_acc + w_term;
  end

  assign w_sat = saturate(r_acc);

`ifdef FC_RELU_EN
  assign result = w_sat[DATA_WIDTH-1] ? '0 : w_sat;
`else
  assign result = w_sat;
`endif

endmodule

// File: rtl/fc_layer.sv
// Fully-connected layer engine: sequences DRAM reads of params, bias, x and w per neuron.
// FC_RELU_EN (in fc_mac) selects ReLU on written results; timing is unchanged.
module fc_layer
  import fc_pkg::*;
#(
  parameter int DATA_WIDTH = FC_DATA_W,
  parameter int ADDR_WIDTH = FC_ADDR_W,
  parameter int FRAC_BITS  = FC_FRAC_BITS,
  parameter int ACC_WIDTH  = FC_ACC_W
) (
  input  logic                  clk,
  input  logic                  srst,
  input  logic                  enable,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  dram_valid,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic [ADDR_WIDTH-1:0] addr_in,
  output logic [ADDR_WIDTH-1:0] addr_out,
  output logic                  dram_en_rd,
  output logic                  dram_en_wr,
  output logic                  done
);

  localparam logic [ADDR_WIDTH-1:0] A_ONE = ADDR_WIDTH'(1);

  fc_state_t             r_state;
  logic [1:0]            r_pcnt;
  logic [10:0]           r_num_in, r_i;
  logic [6:0]            r_num_out, r_o;
  logic [ADDR_WIDTH-1:0] r_wptr, r_addr_in, r_addr_out;
  logic                  r_odd, r_load_bias, r_mac_en;
  logic                  r_rd_en, r_wr_en, r_done;
  logic [DATA_WIDTH-1:0] r_x;
  logic [DATA_WIDTH-1:0] w_result;
  logic                  w_unused;

  // Read latency is fixed at one cycle, so the valid strobe carries no information.
  assign w_unused = dram_valid;

  // Outputs are registered alongside the state they belong to.
  always_ff @(posedge clk) begin
    if (srst) begin
      r_state <= S_IDLE;     r_pcnt <= '0;      r_num_in <= '0;   r_num_out <= '0;
      r_i <= '0;             r_o <= '0;         r_wptr <= '0;     r_odd <= 1'b0;
      r_x <= '0;             r_load_bias <= 1'b0; r_mac_en <= 1'b0;
      r_rd_en <= 1'b0;       r_addr_in <= '0;   r_wr_en <= 1'b0;  r_addr_out <= '0;
      r_done <= 1'b0;
    end else begin
      r_rd_en <= 1'b0;  r_addr_in <= '0;  r_wr_en <= 1'b0;  r_addr_out <= '0;
      r_done <= 1'b0;   r_load_bias <= 1'b0;  r_mac_en <= 1'b0;
      case (r_state)
        S_IDLE: if (enable) begin
          r_state   <= S_LD_PARAM;
          r_pcnt    <= '0;
          r_o       <= '0;
          r_wptr    <= WEIGHT_BASE;
          r_rd_en   <= 1'b1;
          r_addr_in <= PARAM_BASE;
        end
        S_LD_PARAM: begin
          r_pcnt <= r_pcnt + 2'd1;
          if (r_pcnt < 2'(NUM_PARAM-1)) begin
            r_rd_en   <= 1'b1;
            r_addr_in <= PARAM_BASE + ADDR_WIDTH'(r_pcnt) + A_ONE;
          end else if (r_pcnt == 2'(NUM_PARAM-1)) begin
            r_num_in <= data_in[10:0];
          end else begin
            r_num_out <= data_in[6:0];
            if (data_in[6:0] == 7'd0) begin
              r_state <= S_DONE;
              r_done  <= 1'b1;
            end else begin
              r_state   <= S_LD_BIAS;
              r_rd_en   <= 1'b1;
              r_addr_in <= BIAS_BASE;
            end
          end
        end
        S_LD_BIAS: begin
          r_load_bias <= 1'b1;
          r_i         <= '0;
          r_odd       <= 1'b0;
          if (r_num_in == 11'd0) begin
            r_state <= S_FLUSH;
          end else begin
            r_state   <= S_MAC;
            r_rd_en   <= 1'b1;
            r_addr_in <= OFMAP_BASE;
          end
        end
        S_MAC: begin
          if (!r_odd) begin
            r_odd     <= 1'b1;
            r_rd_en   <= 1'b1;
            r_addr_in <= r_wptr;
          end else begin
            r_x      <= data_in;
            r_mac_en <= 1'b1;
            r_wptr   <= r_wptr + A_ONE;
            if (r_i == r_num_in - 11'd1) begin
              r_state <= S_FLUSH;
            end else begin
              r_i       <= r_i + 11'd1;
              r_odd     <= 1'b0;
              r_rd_en   <= 1'b1;
              r_addr_in <= OFMAP_BASE + ADDR_WIDTH'(r_i) + A_ONE;
            end
          end
        end
        S_FLUSH: begin
          r_state    <= S_WRITE;
          r_wr_en    <= 1'b1;
          r_addr_out <= OUT_BASE + ADDR_WIDTH'(r_o);
        end
        S_WRITE: begin
          r_o <= r_o + 7'd1;
          if (({1'b0, r_o} + 8'd1) < {1'b0, r_num_out}) begin
            r_state   <= S_LD_BIAS;
            r_rd_en   <= 1'b1;
            r_addr_in <= BIAS_BASE + ADDR_WIDTH'(r_o) + A_ONE;
          end else begin
            r_state <= S_DONE;
            r_done  <= 1'b1;
          end
        end
        S_DONE:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  fc_mac #(
    .DATA_WIDTH(DATA_WIDTH),
    .ACC_WIDTH (ACC_WIDTH),
    .FRAC_BITS (FRAC_BITS)
  ) u_mac (
    .clk      (clk),
    .srst     (srst),
    .load_bias(r_load_bias),
    .mac_en   (r_mac_en),
    .x        (r_x),
    .w        (data_in),
    .result   (w_result)
  );

  assign dram_en_rd = r_rd_en;
  assign addr_in    = r_addr_in;
  assign dram_en_wr = r_wr_en;
  assign addr_out   = r_addr_out;
  assign data_out   = r_wr_en ? w_result : '0;
  assign done       = r_done;

endmodule

// File: tb/tb_fc_layer.sv
// Scoreboard bench for fc_layer: directed DRAM images, expected writes queued, monitor compares.
module tb_fc_layer;

  localparam int OFMAP  = 65536;
  localparam int WEIGHT = 196608;

  logic        clk = 1'b0;
  logic        srst = 1'b1;
  logic        enable = 1'b0;
  logic        dram_valid = 1'b1;
  logic [31:0] data_in;
  logic [31:0] data_out;
  logic [17:0] addr_in, addr_out;
  logic        dram_en_rd, dram_en_wr, done;

  typedef struct { logic [17:0] a; logic [31:0] d; } wr_t;
  wr_t         exp_q[$];
  logic [31:0] mem [int];

  int checks = 0;
  int errors = 0;
  int big_reads = 0;
  int all_reads = 0;
  int done_cnt = 0;

  always #5 clk = ~clk;

  fc_layer dut (
    .clk(clk), .srst(srst), .enable(enable), .data_in(data_in), .dram_valid(dram_valid),
    .data_out(data_out), .addr_in(addr_in), .addr_out(addr_out),
    .dram_en_rd(dram_en_rd), .dram_en_wr(dram_en_wr), .done(done)
  );

  // DRAM model: one-cycle read latency; junk on the bus when no read was issued.
  always @(posedge clk) begin
    if (dram_en_rd) data_in <= mem.exists(int'(addr_in)) ? mem[int'(addr_in)] : 32'h0;
    else            data_in <= 32'hDEADBEEF;
  end

  // Monitor: pops the scoreboard on every write, tracks reads and done pulses.
  always @(negedge clk) begin
    wr_t e;
    if (dram_en_wr) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_write addr=%0h data=%08h", addr_out, data_out);
      end else begin
        e = exp_q.pop_front();
        if (addr_out !== e.a || data_out !== e.d) begin
          errors++;
          $display("FAIL write got addr=%0h data=%08h expected addr=%0h data=%08h",
                   addr_out, data_out, e.a, e.d);
        end
      end
    end
    if (dram_en_rd) all_reads++;
    if (dram_en_rd && int'(addr_in) >= OFMAP) big_reads++;
    if (done) done_cnt++;
    if (!dram_en_rd && addr_in !== 18'd0) begin
      checks++;
      errors++;
      $display("FAIL addr_in_idle got=%0h expected=0", addr_in);
    end
  end

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h expected=%0h", name, got, exp);
    end
  endtask

  task automatic push_exp(input logic [17:0] a, input logic [31:0] d);
    wr_t e;
    e.a = a;
`ifdef FC_RELU_EN
    e.d = d[31] ? 32'h0 : d;
`else
    e.d = d;
`endif
    exp_q.push_back(e);
  endtask

  task automatic check_outputs_zero(input string name);
    check({name, "_rd"},   dram_en_rd, 0);
    check({name, "_wr"},   dram_en_wr, 0);
    check({name, "_ain"},  addr_in,    0);
    check({name, "_aout"}, addr_out,   0);
    check({name, "_dout"}, data_out,   0);
    check({name, "_done"}, done,       0);
  endtask

  task automatic pulse_enable();
    @(posedge clk); #1 enable = 1'b1;
    @(posedge clk); #1 enable = 1'b0;
  endtask

  // Counts cycles after the enable cycle until done; expects done exactly at exp_lat.
  task automatic wait_done(input string name, input int exp_lat);
    int n = 0;
    bit seen = 0;
    while (!seen && n < exp_lat + 50) begin
      @(negedge clk);
      n++;
      if (done) seen = 1;
    end
    check({name, "_done_seen"}, 64'(seen), 1);
    check({name, "_done_lat"}, 64'(n), 64'(exp_lat));
    @(negedge clk);
    check({name, "_done_single"}, done, 0);
    check({name, "_pending"}, 64'(exp_q.size()), 0);
  endtask

  task automatic setup_base(input int ni, input int no);
    mem.delete();
    mem[0] = 32'(ni);
    mem[1] = 32'(no);
  endtask

  // x=[1.0,2.0,-1.0,0.5], w0 all 1.0, w1 all 0, bias=[0.25,-3.0]
  task automatic setup_t1();
    logic [31:0] xs [4] = '{32'h0001_0000, 32'h0002_0000, 32'hFFFF_0000, 32'h0000_8000};
    setup_base(4, 2);
    mem[16] = 32'h0000_4000;
    mem[17] = 32'hFFFD_0000;
    for (int i = 0; i < 4; i++) begin
      mem[OFMAP + i]      = xs[i];
      mem[WEIGHT + i]     = 32'h0001_0000;
      mem[WEIGHT + 4 + i] = 32'h0;
    end
  endtask

  task automatic push_t1();
    push_exp(18'd1024, 32'h0002_C000);
    push_exp(18'd1025, 32'hFFFD_0000);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int dc;
    int rd0;
    bit seen;

    repeat (3) @(posedge clk);
    #1 srst = 1'b0;
    @(negedge clk);
    check_outputs_zero("reset");

    // basic two-neuron run
    setup_t1();
    push_t1();
    pulse_enable();
    wait_done("basic", 26);

    // positive and negative saturation: 4 x (255.0*255.0) = 260100.0
    setup_base(4, 2);
    mem[16] = 32'h0;
    mem[17] = 32'h0;
    for (int i = 0; i < 4; i++) begin
      mem[OFMAP + i]      = 32'h00FF_0000;
      mem[WEIGHT + i]     = 32'h00FF_0000;
      mem[WEIGHT + 4 + i] = 32'hFF01_0000;
    end
    push_exp(18'd1024, 32'h7FFF_FFFF);
    push_exp(18'd1025, 32'h8000_0000);
    pulse_enable();
    wait_done("sat", 26);

    // arithmetic shift floors: -1 LSB * 0.5 -> -1 LSB
    setup_base(1, 1);
    mem[16]     = 32'h0;
    mem[OFMAP]  = 32'hFFFF_FFFF;
    mem[WEIGHT] = 32'h0000_8000;
    push_exp(18'd1024, 32'hFFFF_FFFF);
    pulse_enable();
    wait_done("floor", 9);

    // num_in = 0: bias passes straight through, no x/w reads
    setup_base(0, 1);
    mem[16] = 32'h0001_2345;
    push_exp(18'd1024, 32'h0001_2345);
    big_reads = 0;
    pulse_enable();
    wait_done("nin0", 7);
    check("nin0_big_reads", 64'(big_reads), 0);

    // num_out = 0: no writes at all
    setup_base(4, 0);
    pulse_enable();
    wait_done("nout0", 4);

    // reset during MAC of neuron 0
    setup_t1();
    pulse_enable();
    repeat (8) @(negedge clk);
    @(posedge clk); #1 srst = 1'b1;
    @(posedge clk); #1 srst = 1'b0;
    @(negedge clk);
    check_outputs_zero("srst");
    dc  = done_cnt;
    rd0 = all_reads;
    repeat (40) @(negedge clk);
    check("srst_no_done",  64'(done_cnt - dc), 0);
    check("srst_no_reads", 64'(all_reads - rd0), 0);
    push_t1();
    pulse_enable();
    wait_done("after_srst", 26);

    // enable held high: one done, then a fresh run from IDLE
    setup_t1();
    push_t1();
    push_t1();
    dc = done_cnt;
    @(posedge clk); #1 enable = 1'b1;
    @(posedge clk); #1;
    n = 0;
    seen = 0;
    while (!seen && n < 80) begin
      @(negedge clk);
      n++;
      if (done) seen = 1;
    end
    check("held_first_lat", 64'(n), 26);
    @(negedge clk);
    check("held_idle_rd", dram_en_rd, 0);
    @(negedge clk);
    check("held_restart_rd", dram_en_rd, 1);
    check("held_restart_addr", addr_in, 0);
    #1 enable = 1'b0;
    n = 28;
    seen = 0;
    while (!seen && n < 120) begin
      @(negedge clk);
      n++;
      if (done) seen = 1;
    end
    check("held_second_lat", 64'(n), 53);
    @(negedge clk);
    check("held_done_count", 64'(done_cnt - dc), 2);
    check("held_pending", 64'(exp_q.size()), 0);

    repeat (5) @(negedge clk);
    check("final_pending", 64'(exp_q.size()), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
